result_packer_bram: RTL and testbench
=====================================

Name: result_packer_bram

Overview:
Parametrised streaming packer between the engine result FIFO and the result BRAM used by host DMA. Each job is started by a command that gives a base address and an element count. The block pops elements at up to one per cycle, packs them into BRAM-width lines, and zero-pads and writes the final partial line. It reports done, lines written and address wrap. It also captures the first NUM_CAP results into registers for bring-up without DMA.

Parameters:
ELEM_W, 16, width of one result element (FP16 by default)
LINE_W, 256, BRAM line width; must be an integer multiple of ELEM_W, and LINE_W/ELEM_W must be a power of 2
ADDR_W, 9, BRAM line address width (512 lines)
CNT_W, 16, width of the per-job element count
NUM_CAP, 4, number of leading results mirrored to capture registers (at least 1, at most LINE_W/ELEM_W)

Ports:
i_clk  in  1  clock; single clock domain
i_reset_n  in  1  reset; asynchronous, active-low
i_start  in  1  job start pulse; accepted only in IDLE
i_base_addr  in  ADDR_W  first BRAM line of the job
i_elem_count  in  CNT_W  number of elements in the job
o_busy  out  1  high from start acceptance until o_done
o_done  out  1  one-cycle pulse at job completion
i_fifo_rdata  in  ELEM_W  FIFO read data; valid the cycle after o_fifo_ren
o_fifo_ren  out  1  FIFO pop; combinational
i_fifo_empty  in  1  FIFO empty flag
o_bram_wr_addr  out  ADDR_W  BRAM write address
o_bram_wr_data  out  LINE_W  packed line; element k at bits [k*ELEM_W +: ELEM_W]
o_bram_wr_en  out  1  BRAM write strobe; one cycle per line
o_capture  out  NUM_CAP*ELEM_W  first NUM_CAP results of the job; element k at [k*ELEM_W +: ELEM_W]
o_line_count  out  ADDR_W+1  lines written in the current or last job
o_wrap  out  1  sticky; the line address wrapped during the current job

Behaviour:
- Reset, asynchronous: every output is 0 and the state is IDLE. The pack buffer, counters and captures are cleared. A reset mid-job abandons the job; no further writes occur and nothing is replayed.
- Localparams: EPL = LINE_W/ELEM_W; LANE_W = log2(EPL).
- State IDLE:
  - i_start latches i_base_addr and i_elem_count.
  - Clears issued_cnt, recv_cnt, lane, buffer, o_capture, o_line_count and o_wrap.
  - Goes to RUN, or to DONE if i_elem_count == 0.
- State RUN:
  - o_fifo_ren = !i_fifo_empty && (issued_cnt != count). This gives one element per cycle with back-to-back reads.
  - rd_vld is o_fifo_ren delayed by one register. On rd_vld the element goes to lane `lane` of the buffer.
  - If recv_cnt < NUM_CAP, the element is also stored in o_capture slot recv_cnt.
  - Line write condition: lane == EPL-1, or this is the last element (recv_cnt == count-1). When it holds, the next cycle has o_bram_wr_en = 1, o_bram_wr_addr = cur_addr, and o_bram_wr_data = buffer merged with the new element, with all lanes above it zero.
  - After a line write: lane clears, buffer clears, cur_addr increments, and o_line_count increments.
  - cur_addr increments modulo 2^ADDR_W. An increment from all-ones sets o_wrap.
  - After the last element, go to DONE.
- State DONE: o_done = 1 and o_busy = 0 for one cycle, then IDLE. o_capture, o_line_count and o_wrap hold until the next i_start.
- i_start while not IDLE is ignored.
- The block has no backpressure from the BRAM side; writes are fire-and-forget.
- Latency:
  - First pop: the cycle after start, if the FIFO is non-empty.
  - Line write: two cycles after the pop of its last element.
  - o_done: the cycle after the last write.
- A FIFO that empties mid-job stalls reads without losing data. Lane state is preserved across empty gaps.

Decomposition:
- Shared package gemm_result_pkg:
  - state enum (IDLE, RUN, DONE)
  - default ELEM_W / LINE_W / ADDR_W constants
  - function lane_mask(lane) returning the zero-pad mask
- One natural sub-module: result_line_assembler (lane counter, buffer, merge, zero-pad, last/full detect). The top keeps the FSM, FIFO read control, addressing and capture.

Test Plan:
- base=0, count=16, FIFO preloaded with 0x3C00+k -> exactly one write: addr 0, data lane k = 0x3C00+k; o_capture = {0x3C03,0x3C02,0x3C01,0x3C00}; o_line_count=1; o_done 1 cycle; o_fifo_ren high 16 consecutive cycles.
- base=10, count=20 -> writes at addr 10 (lanes 0-15) and addr 11 (lanes 0-3 = elems 16-19, lanes 4-15 = 0); o_line_count=2; o_wrap=0.
- count=32 with i_fifo_empty toggled randomly -> same data as the gap-free run; no pop while empty; exactly 2 writes.
- base=511, count=32 -> writes at addr 511 then addr 0; o_wrap=1 after the second write.
- count=0 -> o_done the cycle after start; no o_fifo_ren; no write; o_line_count=0.
- i_reset_n low during element 8 of 16 -> all outputs 0 immediately, no write. i_start asserted while busy -> ignored; the running job completes unchanged.

Source files
------------

// File: rtl/gemm_result_pkg.sv
// Shared types, default widths and the zero-pad mask helper for the result packer.
package gemm_result_pkg;

  localparam int unsigned ELEM_W_DEF  = 16;
  localparam int unsigned LINE_W_DEF  = 256;
  localparam int unsigned ADDR_W_DEF  = 9;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned NUM_CAP_DEF = 4;
  // Widest line the mask helper can describe; callers truncate to their LINE_W.
  localparam int unsigned MASK_W      = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ones over lanes 0..lane, zeros above: keeps a partial line zero-padded.
  function automatic logic [MASK_W-1:0] lane_mask(input int unsigned lane,
                                                  input int unsigned elem_w);
    int unsigned n;
    n = (lane + 1) * elem_w;
    if (n >= MASK_W) lane_mask = {MASK_W{1'b1}};
    else             lane_mask = {MASK_W{1'b1}} >> (MASK_W - n);
  endfunction

endpackage

// File: rtl/result_line_assembler.sv
// Packs one element per valid cycle into a line and emits the line when full or last.
module result_line_assembler
  import gemm_result_pkg::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  logic              i_vld,
  input  logic [ELEM_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_line_wr_c,
  output logic              o_line_vld,
  output logic [LINE_W-1:0] o_line_data
);

  localparam int unsigned EPL    = LINE_W / ELEM_W;
  localparam int unsigned LANE_W = (EPL > 1) ? $clog2(EPL) : 1;

  logic [LANE_W-1:0] r_lane;
  logic [LINE_W-1:0] r_buf;
  logic [LINE_W-1:0] w_mask;
  logic [LINE_W-1:0] w_merged;

  // Insert the incoming element at the current lane and force lanes above it to zero.
  always_comb begin
    w_mask   = LINE_W'(lane_mask(32'(r_lane), ELEM_W));
    w_merged = r_buf;
    for (int unsigned k = 0; k < EPL; k++) begin
      if (r_lane == LANE_W'(k)) w_merged[k*ELEM_W +: ELEM_W] = i_data;
    end
    w_merged = w_merged & w_mask;
  end

  assign o_line_wr_c = i_vld && ((r_lane == LANE_W'(EPL - 1)) || i_last);

  // Lane/buffer state and the registered line write.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lane      <= '0;
      r_buf       <= '0;
      o_line_vld  <= 1'b0;
      o_line_data <= '0;
    end else begin
      o_line_vld <= 1'b0;
      if (i_clear) begin
        r_lane <= '0;
        r_buf  <= '0;
      end else if (i_vld) begin
        if (o_line_wr_c) begin
          o_line_vld  <= 1'b1;
          o_line_data <= w_merged;
          r_lane      <= '0;
          r_buf       <= '0;
        end else begin
          r_buf  <= w_merged;
          r_lane <= r_lane + LANE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/result_packer_bram.sv
// Streams a job's results from the engine FIFO into BRAM lines, with bring-up capture.
module result_packer_bram
  import gemm_result_pkg::*;
#(
  parameter int unsigned ELEM_W  = ELEM_W_DEF,
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned NUM_CAP = NUM_CAP_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_start,
  input  logic [ADDR_W-1:0]         i_base_addr,
  input  logic [CNT_W-1:0]          i_elem_count,
  output logic                      o_busy,
  output logic                      o_done,
  input  logic [ELEM_W-1:0]         i_fifo_rdata,
  output logic                      o_fifo_ren,
  input  logic                      i_fifo_empty,
  output logic [ADDR_W-1:0]         o_bram_wr_addr,
  output logic [LINE_W-1:0]         o_bram_wr_data,
  output logic                      o_bram_wr_en,
  output logic [NUM_CAP*ELEM_W-1:0] o_capture,
  output logic [ADDR_W:0]           o_line_count,
  output logic                      o_wrap
);

  localparam int unsigned LC_W = ADDR_W + 1;

  state_e             r_state;
  state_e             w_state_nx;
  logic               w_start_acc;
  logic               w_ren;
  logic               w_last;
  logic               w_line_wr;
  logic               r_rd_vld;
  logic [ADDR_W-1:0]  r_cur_addr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_issued;
  logic [CNT_W-1:0]   r_recv;

  // Next state and FIFO pop; the job ends once every issued element has landed.
  always_comb begin
    w_state_nx  = r_state;
    w_ren       = 1'b0;
    w_start_acc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_start_acc = 1'b1;
          w_state_nx  = (i_elem_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        w_ren = !i_fifo_empty && (r_issued != r_count);
        if (r_recv == r_count) w_state_nx = ST_DONE;
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign o_fifo_ren = w_ren;
  assign w_last     = (r_recv == r_count - CNT_W'(1));

  // State register with registered status flags.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      o_busy  <= (w_state_nx == ST_RUN);
      o_done  <= (w_state_nx == ST_DONE);
    end
  end

  // Job counters, capture registers and line addressing.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_vld       <= 1'b0;
      r_cur_addr     <= '0;
      r_count        <= '0;
      r_issued       <= '0;
      r_recv         <= '0;
      o_capture      <= '0;
      o_line_count   <= '0;
      o_wrap         <= 1'b0;
      o_bram_wr_addr <= '0;
    end else begin
      r_rd_vld <= w_ren;
      if (w_start_acc) begin
        r_cur_addr   <= i_base_addr;
        r_count      <= i_elem_count;
        r_issued     <= '0;
        r_recv       <= '0;
        o_capture    <= '0;
        o_line_count <= '0;
        o_wrap       <= 1'b0;
      end else begin
        if (w_ren) r_issued <= r_issued + CNT_W'(1);
        if (r_rd_vld) begin
          r_recv <= r_recv + CNT_W'(1);
          for (int unsigned k = 0; k < NUM_CAP; k++) begin
            if (r_recv == CNT_W'(k)) o_capture[k*ELEM_W +: ELEM_W] <= i_fifo_rdata;
          end
        end
        if (w_line_wr) begin
          o_bram_wr_addr <= r_cur_addr;
          r_cur_addr     <= r_cur_addr + ADDR_W'(1);
          o_line_count   <= o_line_count + LC_W'(1);
          if (&r_cur_addr) o_wrap <= 1'b1;
        end
      end
    end
  end

  result_line_assembler #(
    .ELEM_W (ELEM_W),
    .LINE_W (LINE_W)
  ) u_asm (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_clear     (w_start_acc),
    .i_vld       (r_rd_vld),
    .i_data      (i_fifo_rdata),
    .i_last      (w_last),
    .o_line_wr_c (w_line_wr),
    .o_line_vld  (o_bram_wr_en),
    .o_line_data (o_bram_wr_data)
  );

endmodule

// File: tb/tb_result_packer_bram.sv
// Randomized bench for result_packer_bram against a queue-based line model.
module tb_result_packer_bram;

  localparam int unsigned ELEM_W  = 16;
  localparam int unsigned LINE_W  = 256;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned NUM_CAP = 4;
  localparam int unsigned EPL     = LINE_W / ELEM_W;
  localparam int          NLINES  = 512;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } wr_t;

  logic                      i_clk;
  logic                      i_reset_n;
  logic                      i_start;
  logic [ADDR_W-1:0]         i_base_addr;
  logic [CNT_W-1:0]          i_elem_count;
  logic                      o_busy;
  logic                      o_done;
  logic [ELEM_W-1:0]         i_fifo_rdata;
  logic                      o_fifo_ren;
  logic                      i_fifo_empty;
  logic [ADDR_W-1:0]         o_bram_wr_addr;
  logic [LINE_W-1:0]         o_bram_wr_data;
  logic                      o_bram_wr_en;
  logic [NUM_CAP*ELEM_W-1:0] o_capture;
  logic [ADDR_W:0]           o_line_count;
  logic                      o_wrap;

  logic [ELEM_W-1:0] fq[$];
  wr_t               ewq[$];
  int                n_cmp = 0;
  int                n_bad = 0;
  int                cyc = 0;
  bit                gap_en = 0;
  int                pops, first_pop, last_pop, wrs, last_wr, g_start_cyc;
  logic [LINE_W-1:0] last_wr_data;
  logic [ADDR_W-1:0] last_wr_addr;

  result_packer_bram #(
    .ELEM_W(ELEM_W), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .NUM_CAP(NUM_CAP)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_elem_count(i_elem_count), .o_busy(o_busy), .o_done(o_done),
    .i_fifo_rdata(i_fifo_rdata), .o_fifo_ren(o_fifo_ren), .i_fifo_empty(i_fifo_empty),
    .o_bram_wr_addr(o_bram_wr_addr), .o_bram_wr_data(o_bram_wr_data),
    .o_bram_wr_en(o_bram_wr_en), .o_capture(o_capture), .o_line_count(o_line_count),
    .o_wrap(o_wrap)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // FIFO model plus per-cycle checks of pops and line writes against the model queue.
  initial begin
    bit  pop;
    wr_t e;
    forever begin
      @(negedge i_clk);
      i_fifo_empty = (fq.size() == 0) || (gap_en && ($urandom_range(0, 2) == 0));
      #1;
      pop = 1'b0;
      if (i_reset_n) begin
        if (o_fifo_ren) begin
          chk("ren_while_empty", 512'(o_fifo_ren & i_fifo_empty), 512'(0));
          pop = 1'b1;
          pops++;
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
        end
        if (o_bram_wr_en) begin
          wrs++;
          last_wr      = cyc;
          last_wr_data = o_bram_wr_data;
          last_wr_addr = o_bram_wr_addr;
          if (ewq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %0h, required no write", o_bram_wr_addr);
          end else begin
            e = ewq.pop_front();
            chk("wr_addr", 512'(o_bram_wr_addr), 512'(e.addr));
            chk("wr_data", 512'(o_bram_wr_data), 512'(e.data));
          end
        end
      end
      @(posedge i_clk);
      #1;
      if (pop && fq.size() > 0) i_fifo_rdata = fq.pop_front();
      else                      i_fifo_rdata = ELEM_W'($urandom);
    end
  end

  // Build the expected lines/capture for a job, run it, and check completion state.
  task automatic run_job(input int base, input int count, input bit pattern,
                         input bit gaps, input bit poke_busy);
    logic [ELEM_W-1:0]         el[$];
    logic [ELEM_W-1:0]         v;
    wr_t                       w;
    logic [NUM_CAP*ELEM_W-1:0] ecap;
    int                        lines, idx, done_cyc, t;
    bit                        ewrap;
    gap_en = gaps;
    for (int k = 0; k < count; k++) begin
      v = pattern ? ELEM_W'(16'h3C00 + k) : ELEM_W'($urandom);
      el.push_back(v);
      fq.push_back(v);
    end
    lines = (count + EPL - 1) / EPL;
    ewrap = 1'b0;
    for (int j = 0; j < lines; j++) begin
      w.addr = ADDR_W'((base + j) % NLINES);
      w.data = '0;
      for (int l = 0; l < EPL; l++) begin
        idx = j * EPL + l;
        if (idx < count) w.data[l*ELEM_W +: ELEM_W] = el[idx];
      end
      ewq.push_back(w);
      if ((base + j) % NLINES == NLINES - 1) ewrap = 1'b1;
    end
    ecap = '0;
    for (int k = 0; k < NUM_CAP && k < count; k++) ecap[k*ELEM_W +: ELEM_W] = el[k];
    pops = 0; wrs = 0; first_pop = -1; last_pop = -1; last_wr = -1;

    @(negedge i_clk);
    i_start      = 1'b1;
    i_base_addr  = ADDR_W'(base);
    i_elem_count = CNT_W'(count);
    g_start_cyc  = cyc;
    @(negedge i_clk);
    i_start      = 1'b0;
    i_base_addr  = ADDR_W'($urandom);
    i_elem_count = CNT_W'($urandom);
    #2;
    done_cyc = -1;
    if (count > 0) chk("busy_after_start", 512'(o_busy), 512'(1));
    else           chk("done_zero_count", 512'(o_done), 512'(1));
    if (o_done) done_cyc = cyc;
    t = 0;
    while (done_cyc < 0 && t < 3000) begin
      @(negedge i_clk);
      #2;
      i_start = (poke_busy && t == 1);
      if (o_done) done_cyc = cyc;
      t++;
    end
    i_start = 1'b0;
    if (done_cyc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no o_done, required one within 3000 cycles");
    end else begin
      if (count == 0) begin
        chk("done_latency_zero", 512'(done_cyc), 512'(g_start_cyc + 1));
        chk("pops_zero", 512'(pops), 512'(0));
        chk("writes_zero", 512'(wrs), 512'(0));
      end else begin
        chk("done_after_write", 512'(done_cyc), 512'(last_wr + 1));
        chk("write_after_pop", 512'(last_wr), 512'(last_pop + 2));
        chk("pops", 512'(pops), 512'(count));
        chk("writes", 512'(wrs), 512'(lines));
      end
      chk("busy_at_done", 512'(o_busy), 512'(0));
      @(negedge i_clk);
      #2;
      chk("done_pulse", 512'(o_done), 512'(0));
      chk("line_count", 512'(o_line_count), 512'(lines));
      chk("wrap", 512'(o_wrap), 512'(ewrap));
      chk("capture", 512'(o_capture), 512'(ecap));
      chk("model_writes_left", 512'(ewq.size()), 512'(0));
    end
  endtask

  initial begin
    logic [LINE_W-1:0] lit_full;
    int                t;
    i_reset_n    = 1'b0;
    i_start      = 1'b0;
    i_base_addr  = '0;
    i_elem_count = '0;
    i_fifo_rdata = '0;
    i_fifo_empty = 1'b1;
    #1;
    chk("reset_outputs", 512'({o_busy, o_done, o_fifo_ren, o_bram_wr_en, o_bram_wr_addr,
        o_bram_wr_data, o_capture, o_line_count, o_wrap}), 512'(0));
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Single full line with a recognisable pattern.
    run_job(0, 16, 1'b1, 1'b0, 1'b0);
    chk("first_pop_latency", 512'(first_pop), 512'(g_start_cyc + 1));
    chk("ren_consecutive", 512'(last_pop - first_pop), 512'(15));
    chk("cap_literal", 512'(o_capture), 512'(64'h3C03_3C02_3C01_3C00));
    lit_full = 256'h3C0F_3C0E_3C0D_3C0C_3C0B_3C0A_3C09_3C08_3C07_3C06_3C05_3C04_3C03_3C02_3C01_3C00;
    chk("line0_literal", 512'(last_wr_data), 512'(lit_full));
    chk("line_count_literal", 512'(o_line_count), 512'(1));

    // Partial final line is zero padded.
    run_job(10, 20, 1'b1, 1'b0, 1'b0);
    chk("pad_literal", 512'(last_wr_data), 512'(256'h3C13_3C12_3C11_3C10));
    chk("pad_addr_literal", 512'(last_wr_addr), 512'(11));
    chk("wrap_literal_clear", 512'(o_wrap), 512'(0));

    // FIFO gaps must not change the packed data.
    run_job(200, 32, 1'b1, 1'b1, 1'b0);

    // Address wrap from the last line back to 0.
    run_job(511, 32, 1'b0, 1'b1, 1'b0);
    chk("wrap_literal_set", 512'(o_wrap), 512'(1));
    chk("wrap_addr_literal", 512'(last_wr_addr), 512'(0));

    // Empty job.
    run_job(7, 0, 1'b0, 1'b0, 1'b0);

    // Start while busy is ignored.
    run_job(100, 16, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a job.
    for (int k = 0; k < 16; k++) fq.push_back(ELEM_W'($urandom));
    gap_en = 1'b0;
    pops = 0; wrs = 0; first_pop = -1;
    @(negedge i_clk);
    i_start      = 1'b1;
    i_base_addr  = ADDR_W'(40);
    i_elem_count = CNT_W'(16);
    @(negedge i_clk);
    i_start = 1'b0;
    t = 0;
    while (pops < 8 && t < 200) begin
      @(negedge i_clk);
      #2;
      t++;
    end
    chk("reset_reached_elem8", 512'(pops >= 8), 512'(1));
    i_reset_n = 1'b0;
    #1;
    chk("midjob_reset_outputs", 512'({o_busy, o_done, o_fifo_ren, o_bram_wr_en, o_bram_wr_addr,
        o_bram_wr_data, o_capture, o_line_count, o_wrap}), 512'(0));
    fq.delete();
    ewq.delete();
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    pops = 0; wrs = 0;
    repeat (12) @(negedge i_clk);
    #2;
    chk("no_write_after_reset", 512'(wrs), 512'(0));
    chk("no_pop_after_reset", 512'(pops), 512'(0));
    chk("idle_after_reset", 512'({o_busy, o_line_count}), 512'(0));

    // Randomized jobs.
    for (int r = 0; r < 10; r++) begin
      run_job(int'($urandom_range(0, 511)), int'($urandom_range(1, 70)), 1'b0,
              1'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
